// File: rtl/dmem_store_buffer.sv
// Data-memory front end: posts stores into a small FIFO drained over a req/ack bus,
// and stalls loads until the buffer is empty and the read data has returned.
module dmem_store_buffer #(
    parameter int ADDR_W     = 10,
    parameter int WBUF_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              nrst_i,
    input  logic              cpu_rd_en_i,
    input  logic              cpu_wr_en_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [63:0]       cpu_wdata_i,
    input  logic [7:0]        cpu_wmask_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [63:0]       mem_wdata_o,
    output logic [7:0]        mem_wmask_o,
    input  logic              mem_ack_i,
    input  logic [63:0]       mem_rdata_i
);

    localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + 64 + 8;

    typedef enum logic [1:0] {IDLE, WR_BUS, RD_BUS, RD_DONE} state_e;

    state_e            state_q, state_d;
    logic [ENT_W-1:0]  fifo_mem [WBUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, head_idx;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              req_q, req_d, we_q, we_d, rd_hi_q, rd_hi_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [7:0]        wmask_q, wmask_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              fifo_full, fifo_empty, store_req, load_req, push, pop;
    logic [ADDR_W-1:0] cpu_dw_addr;
    logic [ENT_W-1:0]  head_entry;
    logic              unused_addr_bits;

    assign cpu_dw_addr      = cpu_addr_i[ADDR_W+2:3];
    assign unused_addr_bits = ^{cpu_addr_i[31:ADDR_W+3], cpu_addr_i[1:0]};

    always_comb begin
        fifo_full   = (count_q == CNT_W'(WBUF_DEPTH));
        fifo_empty  = (count_q == '0);
        store_req   = cpu_wr_en_i && (cpu_wmask_i != 8'h00);
        load_req    = cpu_rd_en_i && !cpu_wr_en_i;
        push        = store_req && !fifo_full;
        pop         = (state_q == WR_BUS) && mem_ack_i;
        cpu_stall_o = nrst_i && ((store_req && fifo_full) ||
                                 (load_req && (state_q != RD_DONE)));
        // On a pop the next head is one slot further on, so it can be launched back to back.
        head_idx    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    end

    assign head_entry = fifo_mem[head_idx];

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        rdata_d  = rdata_q;
        rd_hi_d  = rd_hi_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = WR_BUS;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    {addr_d, wdata_d, wmask_d} = head_entry;
                end else if (push) begin
                    // Empty buffer: launch the incoming store straight from the core inputs.
                    state_d = WR_BUS;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    {addr_d, wdata_d, wmask_d} = {cpu_dw_addr, cpu_wdata_i, cpu_wmask_i};
                end else if (load_req) begin
                    state_d = RD_BUS;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = cpu_dw_addr;
                    rd_hi_d = cpu_addr_i[2];
                end
            end
            WR_BUS: begin
                if (mem_ack_i) begin
                    if ((count_q > CNT_W'(1)) && !load_req) begin
                        {addr_d, wdata_d, wmask_d} = head_entry;
                    end else begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end
                end
            end
            RD_BUS: begin
                if (mem_ack_i) begin
                    rdata_d = rd_hi_q ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
                    req_d   = 1'b0;
                    state_d = RD_DONE;
                end
            end
            RD_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            rdata_q  <= '0;
            rd_hi_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            rdata_q  <= rdata_d;
            rd_hi_q  <= rd_hi_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (nrst_i && push) begin
            fifo_mem[wr_ptr_q] <= {cpu_dw_addr, cpu_wdata_i, cpu_wmask_i};
        end
    end

    assign cpu_rdata_o = rdata_q;
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_wmask_o = wmask_q;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: directed scenarios plus a random store/load mix checked
// against a program-order memory model and a bus-side memory driven by a req/ack responder.
module tb_dmem_store_buffer;

    localparam int ADDR_W = 10;

    logic        clk, nrst, cpu_rd_en, cpu_wr_en, cpu_stall;
    logic [31:0] cpu_addr, cpu_rdata;
    logic [63:0] cpu_wdata, mem_wdata, mem_rdata;
    logic [7:0]  cpu_wmask, mem_wmask;
    logic        mem_req, mem_we, mem_ack;
    logic [ADDR_W-1:0] mem_addr;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [63:0]       data;
        logic [7:0]        mask;
    } bus_t;

    bus_t        bus_log[$];
    bus_t        exp_wr[$];
    logic [63:0] bus_mem [1024];
    logic [63:0] ref_mem [1024];

    int total = 0;
    int bad   = 0;
    int req_age = 0;
    int ack_delay = 0;
    int unstable_cnt = 0;
    bit ack_en = 0, rand_lat = 0, force_ack = 0;
    logic              prev_we;
    logic [ADDR_W-1:0] prev_addr;
    logic [63:0]       prev_wdata;
    logic [7:0]        prev_wmask;

    dmem_store_buffer #(.ADDR_W(ADDR_W), .WBUF_DEPTH(4)) dut (
        .clk_i(clk), .nrst_i(nrst),
        .cpu_rd_en_i(cpu_rd_en), .cpu_wr_en_i(cpu_wr_en),
        .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata), .cpu_wmask_i(cpu_wmask),
        .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask),
        .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (m[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    // Memory-side responder, evaluated once per cycle just after the clock edge.
    task automatic bus_step();
        bus_t b;
        mem_ack = 1'b0;
        if (force_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = {$urandom, $urandom};
        end else if (mem_req === 1'b1) begin
            if (req_age > 0 && (mem_we !== prev_we || mem_addr !== prev_addr ||
                                mem_wdata !== prev_wdata || mem_wmask !== prev_wmask))
                unstable_cnt++;
            prev_we = mem_we; prev_addr = mem_addr; prev_wdata = mem_wdata; prev_wmask = mem_wmask;
            if (ack_en && req_age >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = bus_mem[mem_addr];
                b.we = mem_we; b.addr = mem_addr; b.data = mem_wdata; b.mask = mem_wmask;
                bus_log.push_back(b);
                if (mem_we) bus_mem[mem_addr] = merge(bus_mem[mem_addr], mem_wdata, mem_wmask);
                req_age = 0;
                if (rand_lat) ack_delay = $urandom_range(0, 3);
            end else begin
                req_age++;
            end
        end else begin
            req_age = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus_step();
    endtask

    task automatic model_store(input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
        bus_t e;
        if (m != 8'h00) begin
            ref_mem[a[12:3]] = merge(ref_mem[a[12:3]], d, m);
            e.we = 1'b1; e.addr = a[12:3]; e.data = d; e.mask = m;
            exp_wr.push_back(e);
        end
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
        cpu_wr_en = 1'b1; cpu_rd_en = 1'b0;
        cpu_addr = a; cpu_wdata = d; cpu_wmask = m;
    endtask

    task automatic test_reset();
        nrst = 1'b0; cpu_rd_en = 1'b0; cpu_wr_en = 1'b0; cpu_addr = '0;
        cpu_wdata = '0; cpu_wmask = '0; mem_ack = 1'b0; mem_rdata = '0; ack_en = 0;
        tick();
        cpu_rd_en = 1'b1;
        #1;
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b expected 0", cpu_stall); end
        tick();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b expected 0", mem_req); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_we: got %b expected 0", mem_we); end
        total++; if (mem_addr !== '0 || mem_wdata !== '0 || mem_wmask !== '0) begin
            bad++; $display("FAIL rst_bus: got addr=%h data=%h mask=%h expected zeros", mem_addr, mem_wdata, mem_wmask);
        end
        total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h expected 0", cpu_rdata); end
        cpu_rd_en = 1'b0;
        nrst = 1'b1;
        repeat (3) tick();
        total++; if (mem_req !== 1'b0 || cpu_stall !== 1'b0) begin
            bad++; $display("FAIL rst_fifo_empty: got req=%b stall=%b expected 0 0", mem_req, cpu_stall);
        end
    endtask

    task automatic test_store();
        int u0;
        ack_en = 1; ack_delay = 1; rand_lat = 0; bus_log.delete(); exp_wr.delete();
        u0 = unstable_cnt;
        drive_store(32'h18, 64'h1122334455667788, 8'hFF);
        model_store(32'h18, 64'h1122334455667788, 8'hFF);
        #1;
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL store_stall: got %b expected 0", cpu_stall); end
        tick();
        cpu_wr_en = 1'b0;
        total++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
            bad++; $display("FAIL store_req: got req=%b we=%b expected 1 1", mem_req, mem_we);
        end
        total++; if (mem_addr !== 10'd3) begin bad++; $display("FAIL store_addr: got %h expected 3", mem_addr); end
        total++; if (mem_wdata !== 64'h1122334455667788 || mem_wmask !== 8'hFF) begin
            bad++; $display("FAIL store_data: got %h/%h expected 1122334455667788/ff", mem_wdata, mem_wmask);
        end
        tick();
        tick();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL store_pop: got req=%b expected 0", mem_req); end
        total++; if (bus_log.size() != 1) begin bad++; $display("FAIL store_count: got %0d expected 1", bus_log.size()); end
        total++; if (unstable_cnt != u0) begin bad++; $display("FAIL store_stable: got %0d expected %0d", unstable_cnt, u0); end
    endtask

    task automatic test_full();
        logic [63:0] d;
        int n;
        ack_en = 0; rand_lat = 0; bus_log.delete(); exp_wr.delete();
        for (int i = 0; i < 4; i++) begin
            d = {$urandom, $urandom};
            drive_store(32'h100 + 32'(i * 8), d, 8'hFF);
            model_store(32'h100 + 32'(i * 8), d, 8'hFF);
            #1;
            total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL full_accept%0d: got stall=%b expected 0", i, cpu_stall); end
            tick();
        end
        d = {$urandom, $urandom};
        drive_store(32'h120, d, 8'h5A);
        #1;
        for (int k = 0; k < 3; k++) begin
            total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL full_stall%0d: got %b expected 1", k, cpu_stall); end
            if (k < 2) begin tick(); #1; end
        end
        ack_en = 1; ack_delay = 0;
        tick(); #1;
        total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL full_pop_cycle: got %b expected 1", cpu_stall); end
        tick(); #1;
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL full_fifth: got %b expected 0", cpu_stall); end
        model_store(32'h120, d, 8'h5A);
        tick();
        cpu_wr_en = 1'b0;
        n = 0;
        while (bus_log.size() < 5 && n < 40) begin tick(); n++; end
        total++; if (bus_log.size() != 5) begin bad++; $display("FAIL full_count: got %0d expected 5", bus_log.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < bus_log.size()) begin
                total++;
                if (bus_log[i].we !== 1'b1 || bus_log[i].addr !== exp_wr[i].addr ||
                    bus_log[i].data !== exp_wr[i].data || bus_log[i].mask !== exp_wr[i].mask) begin
                    bad++; $display("FAIL full_order%0d: got %h/%h/%h expected %h/%h/%h", i, bus_log[i].addr,
                        bus_log[i].data, bus_log[i].mask, exp_wr[i].addr, exp_wr[i].data, exp_wr[i].mask);
                end
            end
        end
        tick();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL full_drained: got req=%b expected 0", mem_req); end
    endtask

    task automatic test_raw();
        int n;
        ack_en = 1; ack_delay = 2; rand_lat = 0; bus_log.delete(); exp_wr.delete();
        drive_store(32'h20, 64'hDEADBEEF_CAFEF00D, 8'hFF);
        model_store(32'h20, 64'hDEADBEEF_CAFEF00D, 8'hFF);
        #1;
        tick();
        cpu_wr_en = 1'b0; cpu_rd_en = 1'b1; cpu_addr = 32'h24;
        #1;
        n = 0;
        while (cpu_stall === 1'b1 && n < 40) begin tick(); #1; n++; end
        total++; if (n >= 40) begin bad++; $display("FAIL raw_timeout: got stall after %0d cycles expected release", n); end
        total++; if (cpu_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL raw_rdata: got %h expected deadbeef", cpu_rdata); end
        tick();
        cpu_rd_en = 1'b0;
        total++; if (bus_log.size() != 2) begin bad++; $display("FAIL raw_count: got %0d expected 2", bus_log.size()); end
        if (bus_log.size() == 2) begin
            total++; if (bus_log[0].we !== 1'b1 || bus_log[1].we !== 1'b0) begin
                bad++; $display("FAIL raw_order: got we %b,%b expected 1,0", bus_log[0].we, bus_log[1].we);
            end
            total++; if (bus_log[1].addr !== 10'd4) begin bad++; $display("FAIL raw_rd_addr: got %h expected 4", bus_log[1].addr); end
        end
    endtask

    task automatic test_latency();
        int n, u0;
        logic [31:0] a, expv;
        ack_en = 1; ack_delay = 3; rand_lat = 0; bus_log.delete();
        u0 = unstable_cnt;
        a = {19'd0, 10'($urandom_range(0, 1023)), 3'b000} | (32'($urandom_range(0, 1)) << 2);
        expv = a[2] ? ref_mem[a[12:3]][63:32] : ref_mem[a[12:3]][31:0];
        cpu_rd_en = 1'b1; cpu_wr_en = 1'b0; cpu_addr = a;
        #1;
        n = 0;
        while (cpu_stall === 1'b1 && n < 40) begin tick(); #1; n++; end
        total++; if (n != 5) begin bad++; $display("FAIL lat_stall: got %0d cycles expected 5", n); end
        total++; if (cpu_rdata !== expv) begin bad++; $display("FAIL lat_rdata: got %h expected %h", cpu_rdata, expv); end
        total++; if (unstable_cnt != u0) begin bad++; $display("FAIL lat_stable: got %0d expected %0d", unstable_cnt, u0); end
        total++; if (bus_log.size() != 1 || bus_log[0].addr !== a[12:3]) begin
            bad++; $display("FAIL lat_addr: got n=%0d expected one read at %h", bus_log.size(), a[12:3]);
        end
        tick();
        cpu_rd_en = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        int n;
        logic [31:0] expv;
        ack_en = 0; rand_lat = 0;
        cpu_rd_en = 1'b1; cpu_wr_en = 1'b0; cpu_addr = 32'h48;
        #1;
        tick();
        total++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin
            bad++; $display("FAIL mid_rd_req: got req=%b we=%b expected 1 0", mem_req, mem_we);
        end
        nrst = 1'b0; mem_ack = 1'b1; mem_rdata = {$urandom, $urandom};
        #1;
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL mid_rst_stall: got %b expected 0", cpu_stall); end
        tick();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL mid_rst_req: got %b expected 0", mem_req); end
        cpu_rd_en = 1'b0; nrst = 1'b1; force_ack = 1;
        tick();
        force_ack = 0;
        tick();
        total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL mid_rdata: got %h expected 0", cpu_rdata); end
        total++; if (mem_req !== 1'b0 || cpu_stall !== 1'b0) begin
            bad++; $display("FAIL mid_idle: got req=%b stall=%b expected 0 0", mem_req, cpu_stall);
        end
        ack_en = 1; ack_delay = 0;
        expv = ref_mem[9][31:0];
        cpu_rd_en = 1'b1; cpu_addr = 32'h48;
        #1;
        n = 0;
        while (cpu_stall === 1'b1 && n < 40) begin tick(); #1; n++; end
        total++; if (n != 2) begin bad++; $display("FAIL mid_reload_lat: got %0d expected 2", n); end
        total++; if (cpu_rdata !== expv) begin bad++; $display("FAIL mid_reload_data: got %h expected %h", cpu_rdata, expv); end
        tick();
        cpu_rd_en = 1'b0;
    endtask

    task automatic test_random();
        int n, r, loads, reads, writes, u0;
        logic [31:0] a, expv;
        logic [63:0] d;
        logic [7:0]  m;
        ack_en = 1; rand_lat = 1; ack_delay = 1; bus_log.delete(); exp_wr.delete();
        loads = 0; u0 = unstable_cnt;
        for (int op = 0; op < 80; op++) begin
            r = $urandom_range(0, 99);
            a = (32'($urandom_range(0, 15)) << 3) | (32'($urandom_range(0, 1)) << 2);
            if (r < 50) begin
                d = {$urandom, $urandom};
                m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                drive_store(a, d, m);
                cpu_rd_en = (r < 5);
                #1;
                if (m == 8'h00) begin
                    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL rnd_drop_nostall: got %b expected 0", cpu_stall); end
                end
                n = 0;
                while (cpu_stall === 1'b1 && n < 40) begin tick(); #1; n++; end
                if (n >= 40) begin total++; bad++; $display("FAIL rnd_store_timeout: got stall expected release"); end
                model_store(a, d, m);
                $display("txn %0d store addr=%h data=%h mask=%h", op, a, d, m);
                tick();
                cpu_wr_en = 1'b0; cpu_rd_en = 1'b0;
            end else if (r < 85) begin
                expv = a[2] ? ref_mem[a[12:3]][63:32] : ref_mem[a[12:3]][31:0];
                cpu_rd_en = 1'b1; cpu_wr_en = 1'b0; cpu_addr = a;
                #1;
                n = 0;
                while (cpu_stall === 1'b1 && n < 60) begin tick(); #1; n++; end
                total++; if (cpu_rdata !== expv || n >= 60) begin
                    bad++; $display("FAIL rnd_load%0d: got %h expected %h (addr %h)", op, cpu_rdata, expv, a);
                end
                $display("txn %0d load  addr=%h data=%h", op, a, cpu_rdata);
                loads++;
                tick();
                cpu_rd_en = 1'b0;
            end else begin
                tick();
            end
        end
        n = 0; writes = 0;
        while (n < 200) begin
            writes = 0;
            foreach (bus_log[i]) if (bus_log[i].we) writes++;
            if (writes >= exp_wr.size() && mem_req !== 1'b1) break;
            tick(); n++;
        end
        reads = 0; writes = 0;
        foreach (bus_log[i]) begin
            if (bus_log[i].we) begin
                if (writes < exp_wr.size()) begin
                    total++;
                    if (bus_log[i].addr !== exp_wr[writes].addr || bus_log[i].data !== exp_wr[writes].data ||
                        bus_log[i].mask !== exp_wr[writes].mask) begin
                        bad++; $display("FAIL rnd_write%0d: got %h/%h/%h expected %h/%h/%h", writes,
                            bus_log[i].addr, bus_log[i].data, bus_log[i].mask,
                            exp_wr[writes].addr, exp_wr[writes].data, exp_wr[writes].mask);
                    end
                end
                writes++;
            end else begin
                reads++;
            end
        end
        total++; if (writes != exp_wr.size()) begin bad++; $display("FAIL rnd_write_count: got %0d expected %0d", writes, exp_wr.size()); end
        total++; if (reads != loads) begin bad++; $display("FAIL rnd_read_count: got %0d expected %0d", reads, loads); end
        for (int i = 0; i < 16; i++) begin
            total++; if (bus_mem[i] !== ref_mem[i]) begin
                bad++; $display("FAIL rnd_mem%0d: got %h expected %h", i, bus_mem[i], ref_mem[i]);
            end
        end
        total++; if (unstable_cnt != u0) begin bad++; $display("FAIL rnd_stable: got %0d expected %0d", unstable_cnt, u0); end
    endtask

    initial begin
        logic [63:0] v;
        for (int i = 0; i < 1024; i++) begin
            v = {$urandom, $urandom};
            bus_mem[i] = v;
            ref_mem[i] = v;
        end
        test_reset();
        test_store();
        test_full();
        test_raw();
        test_latency();
        test_reset_mid_load();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
